// File: rtl/uart_receiver.sv
// 8N1 UART receive stage: double-flop synchronizer, mid-bit sampling FSM and a
// one-entry valid/ready output buffer with framing-error and overrun pulses.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_rxd,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   input  logic       i_rx_ready,
   output logic       o_rx_busy,
   output logic       o_frame_err,
   output logic       o_overrun
);

   localparam int HALF = CLKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLKS_PER_BIT);

   localparam logic [CW-1:0] C_HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] C_FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_ZERO    = CW'(0);
   localparam logic [CW-1:0] C_ONE     = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic          r_sync1;
   logic          r_sync2;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
   logic          r_armed;
   logic          r_good;
   logic          r_bad;
   logic          w_rxd_s;

   assign w_rxd_s = r_sync2;

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_rxd;
         r_sync2 <= r_sync1;
      end
   end

   // Frame FSM; r_good / r_bad are one-cycle results of the stop-bit sample.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= C_ZERO;
         r_bit_idx <= 3'd0;
         r_shift   <= 8'h00;
         r_armed   <= 1'b1;
         r_good    <= 1'b0;
         r_bad     <= 1'b0;
         o_rx_busy <= 1'b0;
      end else begin
         r_good <= 1'b0;
         r_bad  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= C_ZERO;
               if (w_rxd_s) begin
                  r_armed <= 1'b1;
               end else begin
                  r_armed <= r_armed;
               end
               // A start edge is accepted only once the line has been seen high.
               if (r_armed && !w_rxd_s) begin
                  r_state   <= S_START;
                  o_rx_busy <= 1'b1;
               end else begin
                  o_rx_busy <= 1'b0;
               end
            end
            S_START: begin
               if (r_cnt == C_HALF_M1) begin
                  r_cnt <= C_ZERO;
                  if (w_rxd_s) begin
                     r_state   <= S_IDLE;
                     o_rx_busy <= 1'b0;
                  end else begin
                     r_state   <= S_DATA;
                     r_bit_idx <= 3'd0;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_DATA: begin
               if (r_cnt == C_FULL_M1) begin
                  r_cnt   <= C_ZERO;
                  r_shift <= {w_rxd_s, r_shift[7:1]};
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            S_STOP: begin
               if (r_cnt == C_FULL_M1) begin
                  r_cnt     <= C_ZERO;
                  r_state   <= S_IDLE;
                  o_rx_busy <= 1'b0;
                  if (w_rxd_s) begin
                     r_good <= 1'b1;
                  end else begin
                     r_bad   <= 1'b1;
                     r_armed <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt + C_ONE;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_cnt     <= C_ZERO;
               o_rx_busy <= 1'b0;
            end
         endcase
      end
   end

   // One-entry output buffer; a load and a transfer in the same cycle keep it full.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rx_data   <= 8'h00;
         o_rx_valid  <= 1'b0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
      end else begin
         o_frame_err <= r_bad;
         o_overrun   <= 1'b0;
         if (r_good) begin
            if (!o_rx_valid || i_rx_ready) begin
               o_rx_data  <= r_shift;
               o_rx_valid <= 1'b1;
            end else begin
               o_overrun <= 1'b1;
            end
         end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
         end else begin
            o_rx_valid <= o_rx_valid;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver: reset, latency, glitch,
// framing error, overrun/back-pressure, back-to-back frames and mid-frame reset.
module tb_uart_receiver;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   int         n_vcyc     = 0;
   int         n_ferr     = 0;
   int         n_ovr      = 0;
   int         n_unstable = 0;
   logic [7:0] q_got[$];
   logic       prev_hold  = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_rxd      (rxd),
      .o_rx_data  (rx_data),
      .o_rx_valid (rx_valid),
      .i_rx_ready (rx_ready),
      .o_rx_busy  (rx_busy),
      .o_frame_err(frame_err),
      .o_overrun  (overrun)
   );

   always #5 clk = ~clk;

   // Output monitor: pulse counters, accepted bytes, and hold-stability of rx_data.
   always @(negedge clk) begin
      if (rx_valid) n_vcyc++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (rx_valid && rx_ready) q_got.push_back(rx_data);
      if (prev_hold && rx_valid && (rx_data != prev_data)) n_unstable++;
      prev_hold = rx_valid && !rx_ready;
      prev_data = rx_data;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic stop_bit);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
      rxd = stop_bit;
      tick(CPB);
   endtask

   initial begin
      int bad_idle;
      int lat;
      int nb;
      int nb_frame;
      logic [7:0] got_a5;
      int base_v;
      int base_f;
      int base_o;
      int base_q;

      rst      = 1'b1;
      rxd      = 1'b1;
      rx_ready = 1'b1;
      tick(4);
      check_eq("rst_data", {24'h0, rx_data}, 32'h0);
      check_eq("rst_flags", {28'h0, rx_valid, rx_busy, frame_err, overrun}, 32'h0);
      rst = 1'b0;

      bad_idle = 0;
      repeat (100) begin
         @(negedge clk);
         if (rx_valid || rx_busy || frame_err || overrun || (rx_data != 8'h00)) bad_idle++;
      end
      check_eq("idle_quiet", bad_idle, 32'd0);
      tick(1);

      // Single frame 0xA5: latency from the falling edge and busy width.
      base_v   = n_vcyc;
      lat      = -1;
      nb_frame = 0;
      got_a5   = 8'h00;
      fork
         send(8'hA5, 1'b1);
         begin
            int k;
            k = 0;
            while (k < 300 && lat < 0) begin
               @(posedge clk);
               k++;
               @(negedge clk);
               if (rx_busy) nb_frame++;
               if (rx_valid) begin
                  lat    = k;
                  got_a5 = rx_data;
               end
            end
         end
      join
      tick(4);
      check_eq("a5_latency", lat, 32'd156);
      check_eq("a5_data", {24'h0, got_a5}, 32'hA5);
      check_eq("a5_busy_cycles", nb_frame, 32'd152);
      check_eq("a5_valid_cycles", n_vcyc - base_v, 32'd1);
      check_eq("a5_ferr", n_ferr, 32'd0);
      check_eq("a5_ovr", n_ovr, 32'd0);

      // Glitch: 4 low cycles must be rejected at the mid-start sample.
      base_v = n_vcyc;
      nb     = 0;
      rxd    = 1'b0;
      for (int i = 0; i < 44; i++) begin
         if (i == 4) rxd = 1'b1;
         @(negedge clk);
         if (rx_busy) nb++;
         @(posedge clk);
         #1;
      end
      check_eq("glitch_busy_cycles", nb, 32'd8);
      check_eq("glitch_valid", n_vcyc - base_v, 32'd0);
      check_eq("glitch_ferr", n_ferr, 32'd0);

      // Framing error on 0x3C, line stuck low, then a good 0x55.
      base_v = n_vcyc;
      base_f = n_ferr;
      base_q = q_got.size();
      send(8'h3C, 1'b0);
      rxd = 1'b0;
      nb  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rx_busy) nb++;
         @(posedge clk);
         #1;
      end
      check_eq("ferr_no_false_start", nb, 32'd0);
      check_eq("ferr_pulses", n_ferr - base_f, 32'd1);
      rxd = 1'b1;
      tick(16);
      send(8'h55, 1'b1);
      tick(8);
      check_eq("ferr_valid_cycles", n_vcyc - base_v, 32'd1);
      check_eq("ferr_q_len", q_got.size() - base_q, 32'd1);
      check_eq("ferr_byte_55", {24'h0, q_got[base_q]}, 32'h55);
      check_eq("ferr_pulses_total", n_ferr - base_f, 32'd1);

      // Back-pressure: 0x11 held, 0x22 dropped with one overrun pulse.
      rx_ready = 1'b0;
      base_o   = n_ovr;
      base_q   = q_got.size();
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      tick(10);
      check_eq("ovr_valid_held", {31'h0, rx_valid}, 32'd1);
      check_eq("ovr_data_held", {24'h0, rx_data}, 32'h11);
      check_eq("ovr_pulses", n_ovr - base_o, 32'd1);
      rx_ready = 1'b1;
      tick(1);
      check_eq("ovr_valid_dropped", {31'h0, rx_valid}, 32'd0);
      check_eq("ovr_q_len", q_got.size() - base_q, 32'd1);
      check_eq("ovr_byte_11", {24'h0, q_got[base_q]}, 32'h11);

      // Back-to-back 0x00 / 0xFF, then reset in the middle of a third frame.
      base_q = q_got.size();
      base_f = n_ferr;
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      tick(8);
      check_eq("b2b_q_len", q_got.size() - base_q, 32'd2);
      check_eq("b2b_byte0", {24'h0, q_got[base_q]}, 32'h00);
      check_eq("b2b_byte1", {24'h0, q_got[base_q + 1]}, 32'hFF);
      base_q = q_got.size();
      fork
         send(8'hFF, 1'b1);
         begin
            tick(90);
            check_eq("mid_busy_before_rst", {31'h0, rx_busy}, 32'd1);
            rst = 1'b1;
            tick(1);
            check_eq("mid_rst_busy", {31'h0, rx_busy}, 32'd0);
            check_eq("mid_rst_valid", {31'h0, rx_valid}, 32'd0);
            rst = 1'b0;
         end
      join
      tick(200);
      check_eq("mid_rst_no_byte", q_got.size() - base_q, 32'd0);
      check_eq("mid_rst_no_ferr", n_ferr - base_f, 32'd0);
      check_eq("data_stable_hold", n_unstable, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage paired with the team's UART transmitter: it recovers 8N1 frames (start bit, 8 data bits LSB first, stop bit) from the serial line and presents each byte on a one-entry valid/ready output buffer. It sits directly downstream of the transmitter's `txd` output, or of an external RX pin, and feeds byte-wide consumers.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be an even number ≥ 4. `HALF` = `CLKS_PER_BIT/2`.
- `clk`  in  1  system clock. The block uses one clock only.
- `rst`  in  1  reset, synchronous and active-high.
- `rxd`  in  1  serial input. Asynchronous. Idles high.
- `rx_data`  out  8  received byte. Stable while `rx_valid`=1.
- `rx_valid`  out  1  buffer holds an unconsumed byte.
- `rx_ready`  in  1  consumer accepts the byte. A transfer happens when `rx_valid && rx_ready`.
- `rx_busy`  out  1  a frame is being received (state ≠ IDLE).
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `overrun`  out  1  one-cycle pulse when a good byte is dropped because the buffer is full.

## Operation
- Synchronizer: two flops on `rxd`, both reset to 1. Internal signal `rxd_s` is the second stage, giving 2 cycles of latency. All sampling uses `rxd_s` only.
- Counters: bit-time counter `cnt` (width clog2(`CLKS_PER_BIT`)), bit index `bit_idx` (0..7), 8-bit shift register, and an `armed` flag.
- The state machine has four states: IDLE, START, DATA and STOP.
- IDLE:
  - If `rxd_s`=1, set `armed`=1.
  - If `armed` && `rxd_s`=0, go to START with `cnt`=0.
- START:
  - Increment `cnt`. When `cnt`==`HALF`-1, sample `rxd_s` (mid start bit).
  - If the sample is 1 (glitch), return to IDLE. Nothing is reported.
  - If the sample is 0, go to DATA with `cnt`=0 and `bit_idx`=0.
- DATA:
  - Increment `cnt`. When `cnt`==`CLKS_PER_BIT`-1 (mid-bit), shift right with `rxd_s` entering bit 7, then reset `cnt` to 0.
  - After the sample with `bit_idx`==7, go to STOP. Otherwise increment `bit_idx`.
- STOP:
  - At `cnt`==`CLKS_PER_BIT`-1, sample `rxd_s` and return to IDLE.
  - Sample 1 (good frame): deliver the byte to the buffer.
  - Sample 0 (framing error): pulse `frame_err` the next cycle, discard the byte, set `armed`=0. No new start is accepted until the line has been seen high.
- Returning to IDLE at mid stop bit allows back-to-back frames.
- Output buffer, updated on the cycle after a good stop sample:
  - If `rx_valid`=0, or a transfer happens that same cycle: load `rx_data` and set `rx_valid`=1.
  - Otherwise the new byte is dropped, the old byte is kept, and `overrun` pulses for 1 cycle.
  - A transfer with no new load clears `rx_valid` on the next cycle.
  - A transfer and a new load in the same cycle keep `rx_valid`=1 and replace `rx_data`.
- Reset values:
  - Outputs: `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0.
  - Internal: state IDLE, counters 0, `armed`=1, synchronizer flops 1.
- Reset during a frame abandons the frame. The partial byte is never delivered.

## Timing
- Synchronizer delay is 2 cycles. START is entered on the cycle after IDLE sees `rxd_s`=0.
- The start sample is taken `HALF` cycles after entering START. Data bit n is sampled (n+1)·`CLKS_PER_BIT` cycles after the start sample. The stop sample follows at 9·`CLKS_PER_BIT`.
- The following all occur on the cycle after the stop sample: `rx_valid` rises, `frame_err` pulses, or `overrun` pulses.
- Nominal latency from the `rxd` falling edge to `rx_valid` is 3 + `HALF` + 9·`CLKS_PER_BIT` + 1 cycles. With the default, that is 156 cycles.
- `rx_busy` is high from the START entry cycle through the stop-sample cycle. It is low the next cycle.
- `rx_ready` has no effect while `rx_valid`=0. `rx_data` must not change while `rx_valid`=1 unless a transfer happens.

## Test plan
- Reset: assert `rst` with `rxd`=1 → all outputs 0 and `rx_data`=0x00. They stay so for 100 idle cycles after release.
- Single frame 0xA5, `CLKS_PER_BIT`=16, `rx_ready`=1 → one-cycle `rx_valid` with `rx_data`=0xA5, 156 cycles after the falling edge. `frame_err`=0, `overrun`=0.
- Glitch: `rxd` low for 4 cycles, then high → `rx_busy` high for `HALF` cycles, then low. No `rx_valid`, no `frame_err`.
- Frame 0x3C with stop bit 0, line held low 20 more cycles, then frame 0x55 → single `frame_err` pulse and no `rx_valid` for 0x3C. No false start while the line is low. 0x55 is then delivered correctly.
- `rx_ready`=0, frames 0x11 then 0x22 back-to-back → `rx_valid`=1 with 0x11 held. `overrun` pulses once after the second stop. Raising `rx_ready` transfers 0x11, then `rx_valid` drops.
- Back-to-back 0x00, 0xFF with `rx_ready`=1 → both delivered in order. Then assert `rst` mid-way through a third frame → `rx_busy`=0 and `rx_valid`=0 next cycle, and no byte is delivered from that frame.
